// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: grant, issue, capture, respond.
// Define ALU_ARB_FIXED_PRIORITY_EN to make requester 0 always win ties (default: round-robin).
module alu_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_opcode,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_opcode,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] alu_opcode,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic         alu_negative,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  input  logic         alu_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] res_q, res_d;
  logic [3:0]   flg_q, flg_d;
  logic         id_q, id_d;
  logic         gnt0, gnt1;

`ifndef ALU_ARB_FIXED_PRIORITY_EN
  logic         last_q, last_d;
`endif

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flg_d   = flg_q;
    id_d    = id_q;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          state_d = EXEC;
          id_d    = gnt1;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
          last_d  = gnt1;
`endif
          if (gnt1) begin
            op_d = req1_opcode;
            a_d  = req1_a;
            b_d  = req1_b;
          end else begin
            op_d = req0_opcode;
            a_d  = req0_a;
            b_d  = req0_b;
          end
        end
      end
      EXEC: begin
        res_d   = alu_result;
        flg_d   = {alu_negative, alu_overflow,
                   alu_zero, alu_cout};
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      id_q    <= id_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIORITY_EN
  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU attached.
// Opcodes of the model ALU: 0 ADD, 1 SUB, 2 AND, 3 XOR, others pass a.
module tb_alu_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_opcode, req0_a, req0_b;
  logic [W-1:0] req1_opcode, req1_a, req1_b;
  logic [W-1:0] alu_opcode, alu_a, alu_b;
  logic [W-1:0] alu_result;
  logic         alu_negative, alu_overflow;
  logic         alu_zero, alu_cout;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  exp_t sbq[$];
  int   gq[$];
  int   gcq[$];
  int   gcyc;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_opcode(req0_opcode), .req0_a(req0_a),
    .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_opcode(req1_opcode), .req1_a(req1_a),
    .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result),
    .alu_negative(alu_negative),
    .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {result, negative, overflow, zero, cout}.
  function automatic logic [W+3:0] alu_f(
    input logic [W-1:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      1: begin
        s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2: r = a & b;
      3: r = a ^ b;
      default: r = a;
    endcase
    return {r, r[W-1], v, (r == '0), c};
  endfunction

  always_comb
    {alu_result, alu_negative, alu_overflow,
     alu_zero, alu_cout} = alu_f(alu_opcode, alu_a, alu_b);

  task automatic push(input logic id);
    exp_t e;
    logic [W+3:0] v;
    if (id) v = alu_f(req1_opcode, req1_a, req1_b);
    else    v = alu_f(req0_opcode, req0_a, req0_b);
    e.id  = id;
    e.res = v[W+3:4];
    e.flg = v[3:0];
    sbq.push_back(e);
    gq.push_back(int'(id));
    gcq.push_back(cyc);
    gcyc = cyc;
  endtask

  // Sample point: mid-cycle, records grants into the scoreboard.
  task automatic smp();
    @(negedge clk);
    if (req0_ready) push(1'b0);
    if (req1_ready) push(1'b1);
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      smp();
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        break;
      end
      drv();
    end
  endtask

  task automatic wait_rsp(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      smp();
      if (rsp_valid && rsp_ready) begin
        got = 1'b1;
        break;
      end
      drv();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) smp();
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=00",
               {req0_ready, req1_ready});
    end
    checks++;
    if ({rsp_valid, busy, rsp_id} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000",
               {rsp_valid, busy, rsp_id});
    end
    checks++;
    if ({rsp_result, rsp_flags} !== '0) begin
      errors++;
      $display("FAIL reset_payload got=%h/%b exp=0/0000",
               rsp_result, rsp_flags);
    end
    checks++;
    if ({alu_opcode, alu_a, alu_b} !== '0) begin
      errors++;
      $display("FAIL reset_alu got=%h %h %h exp=0 0 0",
               alu_opcode, alu_a, alu_b);
    end
    drv();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    drv();
  endtask

  task automatic test_single();
    bit   got;
    exp_t e;
    req0_valid = 1'b1;
    req0_opcode = 4'd0;
    req0_a = 4'd3;
    req0_b = 4'd4;
    rsp_ready = 1'b1;
    wait_gnt(10, got);
    checks++;
    if (!got || !req0_ready || req1_ready) begin
      errors++;
      $display("FAIL single_grant got=%b%b exp=10",
               req0_ready, req1_ready);
    end
    drv();
    req0_valid = 1'b0;
    wait_rsp(10, got);
    checks++;
    if (!got || cyc - gcyc != 2) begin
      errors++;
      $display("FAIL single_latency got=%0d exp=2",
               got ? cyc - gcyc : -1);
    end
    checks++;
    if (!got || {rsp_id, rsp_result, rsp_flags}
                !== {1'b0, 4'd7, 4'b0000}) begin
      errors++;
      $display("FAIL single_value got=%b/%0d/%b exp=0/7/0000",
               rsp_id, rsp_result, rsp_flags);
    end
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({rsp_id, rsp_result, rsp_flags}
          !== {e.id, e.res, e.flg}) begin
        errors++;
        $display("FAIL single_sb got=%b/%h/%b exp=%b/%h/%b",
                 rsp_id, rsp_result, rsp_flags,
                 e.id, e.res, e.flg);
      end
    end
    drv();
  endtask

  task automatic test_flags();
    bit   got;
    exp_t e;
    logic [W+3:0] m;
    req1_valid = 1'b1;
    req1_opcode = 4'd1;
    req1_a = 4'd2;
    req1_b = 4'd2;
    m = alu_f(req1_opcode, req1_a, req1_b);
    wait_gnt(10, got);
    checks++;
    if (!got || req0_ready || !req1_ready) begin
      errors++;
      $display("FAIL flags_grant got=%b%b exp=01",
               req0_ready, req1_ready);
    end
    drv();
    req1_valid = 1'b0;
    wait_rsp(10, got);
    checks++;
    if (!got || rsp_id !== 1'b1 || rsp_result !== 4'd0
        || rsp_flags[1] !== 1'b1) begin
      errors++;
      $display("FAIL flags_zero got=%b/%0d/%b exp=1/0/zero=1",
               rsp_id, rsp_result, rsp_flags);
    end
    checks++;
    if (!got || rsp_flags[0] !== m[0]) begin
      errors++;
      $display("FAIL flags_cout got=%b exp=%b",
               rsp_flags[0], m[0]);
    end
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({rsp_id, rsp_result, rsp_flags}
          !== {e.id, e.res, e.flg}) begin
        errors++;
        $display("FAIL flags_sb got=%b/%h/%b exp=%b/%h/%b",
                 rsp_id, rsp_result, rsp_flags,
                 e.id, e.res, e.flg);
      end
    end
    drv();
  endtask

  task automatic test_tie();
    bit   got;
    bit   both;
    exp_t e;
    int   exp_g[4];
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    gq.delete();
    gcq.delete();
    both = 1'b0;
    req0_valid = 1'b1;
    req0_opcode = 4'd0;
    req0_a = 4'd1;
    req0_b = 4'd2;
    req1_valid = 1'b1;
    req1_opcode = 4'd3;
    req1_a = 4'd5;
    req1_b = 4'd3;
    rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      smp();
      if (req0_ready && req1_ready) both = 1'b1;
      if (rsp_valid && rsp_ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if ({rsp_id, rsp_result, rsp_flags}
            !== {e.id, e.res, e.flg}) begin
          errors++;
          $display("FAIL tie_sb got=%b/%h/%b exp=%b/%h/%b",
                   rsp_id, rsp_result, rsp_flags,
                   e.id, e.res, e.flg);
        end
      end
      drv();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (both) begin
      errors++;
      $display("FAIL tie_both_ready got=1 exp=0");
    end
    checks++;
    if (gq.size() < 4) begin
      errors++;
      $display("FAIL tie_count got=%0d exp>=4", gq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gq[i] != exp_g[i]) begin
          errors++;
          $display("FAIL tie_order[%0d] got=%0d exp=%0d",
                   i, gq[i], exp_g[i]);
        end
      end
      checks++;
      if (gcq[1] - gcq[0] != 3) begin
        errors++;
        $display("FAIL tie_spacing got=%0d exp=3",
                 gcq[1] - gcq[0]);
      end
    end
    while (sbq.size() > 0) begin
      wait_rsp(10, got);
      e = sbq.pop_front();
      checks++;
      if (!got || {rsp_id, rsp_result, rsp_flags}
                  !== {e.id, e.res, e.flg}) begin
        errors++;
        $display("FAIL tie_drain got=%b/%h/%b exp=%b/%h/%b",
                 rsp_id, rsp_result, rsp_flags,
                 e.id, e.res, e.flg);
      end
      drv();
    end
  endtask

  task automatic test_backpressure();
    bit   got;
    bit   ok;
    exp_t e;
    logic [W+4:0] snap;
    rsp_ready = 1'b0;
    req0_valid = 1'b1;
    req0_opcode = 4'd2;
    req0_a = 4'hC;
    req0_b = 4'hA;
    wait_gnt(10, got);
    drv();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_opcode = 4'd0;
    req1_a = 4'd7;
    req1_b = 4'd1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      drv();
    end
    snap = {rsp_id, rsp_result, rsp_flags};
    checks++;
    if (!got || snap !== {1'b0, 4'h8, 4'b1000}) begin
      errors++;
      $display("FAIL bp_value got=%b exp=0_1000_1000", snap);
    end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv();
      smp();
      if (!rsp_valid || !busy || req0_ready || req1_ready
          || {rsp_id, rsp_result, rsp_flags} !== snap)
        ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_hold got=v%b b%b r%b%b p%b exp=stable",
               rsp_valid, busy, req0_ready, req1_ready,
               {rsp_id, rsp_result, rsp_flags});
    end
    drv();
    rsp_ready = 1'b1;
    smp();
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (!rsp_valid || {rsp_id, rsp_result, rsp_flags}
                        !== {e.id, e.res, e.flg}) begin
        errors++;
        $display("FAIL bp_sb got=%b/%h/%b exp=%b/%h/%b",
                 rsp_id, rsp_result, rsp_flags,
                 e.id, e.res, e.flg);
      end
    end
    drv();
    smp();
    checks++;
    if (busy !== 1'b0 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got=busy%b r1%b exp=busy0 r11",
               busy, req1_ready);
    end
    drv();
    req1_valid = 1'b0;
    wait_rsp(10, got);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (!got || {rsp_id, rsp_result, rsp_flags}
                  !== {e.id, e.res, e.flg}) begin
        errors++;
        $display("FAIL bp_next got=%b/%h/%b exp=%b/%h/%b",
                 rsp_id, rsp_result, rsp_flags,
                 e.id, e.res, e.flg);
      end
    end
    drv();
  endtask

  task automatic test_withdraw();
    bit   got;
    bit   seen1;
    exp_t e;
    seen1 = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b1;
    req0_opcode = 4'd3;
    req0_a = 4'd9;
    req0_b = 4'd6;
    wait_gnt(10, got);
    drv();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_opcode = 4'd0;
    req1_a = 4'd1;
    req1_b = 4'd1;
    for (int i = 0; i < 2; i++) begin
      smp();
      if (req1_ready) seen1 = 1'b1;
      drv();
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (req1_ready) seen1 = 1'b1;
      if (rsp_valid && rsp_ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if ({rsp_id, rsp_result, rsp_flags}
            !== {e.id, e.res, e.flg} || rsp_id !== 1'b0) begin
          errors++;
          $display("FAIL wd_rsp got=%b/%h/%b exp=%b/%h/%b",
                   rsp_id, rsp_result, rsp_flags,
                   e.id, e.res, e.flg);
        end
      end
      drv();
    end
    checks++;
    if (seen1 || sbq.size() != 0) begin
      errors++;
      $display("FAIL wd_dropped got=seen%b left%0d exp=0 0",
               seen1, sbq.size());
    end
  endtask

  task automatic test_reset_mid();
    bit   got;
    bit   stray;
    exp_t e;
    rsp_ready = 1'b1;
    req0_valid = 1'b1;
    req0_opcode = 4'd0;
    req0_a = 4'd5;
    req0_b = 4'd5;
    wait_gnt(10, got);
    drv();
    req0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_exec got=busy%b v%b exp=busy1 v0",
               busy, rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id,
         rsp_result, rsp_flags, alu_opcode, alu_a, alu_b}
        !== '0) begin
      errors++;
      $display("FAIL rm_zero got=%b%b%b%b%b %h %b %h %h %h exp=0",
               rsp_valid, busy, req0_ready, req1_ready, rsp_id,
               rsp_result, rsp_flags, alu_opcode, alu_a, alu_b);
    end
    sbq.delete();
    drv();
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (rsp_valid || busy) stray = 1'b1;
      drv();
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL rm_discard got=rsp_after_reset exp=none");
    end
    req1_valid = 1'b1;
    req1_opcode = 4'd1;
    req1_a = 4'd3;
    req1_b = 4'd5;
    wait_gnt(10, got);
    drv();
    req1_valid = 1'b0;
    wait_rsp(10, got);
    checks++;
    if (!got || sbq.size() == 0) begin
      errors++;
      $display("FAIL rm_recover got=%b exp=1", got);
    end else begin
      e = sbq.pop_front();
      checks++;
      if ({rsp_id, rsp_result, rsp_flags}
          !== {e.id, e.res, e.flg}) begin
        errors++;
        $display("FAIL rm_sb got=%b/%h/%b exp=%b/%h/%b",
                 rsp_id, rsp_result, rsp_flags,
                 e.id, e.res, e.flg);
      end
    end
    drv();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_opcode = '0;
    req0_a = '0;
    req0_b = '0;
    req1_opcode = '0;
    req1_a = '0;
    req1_b = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_flags();
    test_tie();
    test_backpressure();
    test_withdraw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, giving the opcode/operand/result width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-006 SHALL have ports req0_opcode / req1_opcode  input  W  ALU opcode of requester 0/1.
REQ-007 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  W  operands of requester 0/1.
REQ-008 SHALL have ports alu_opcode, alu_a, alu_b  output  W  operation driven to the shared combinational ALU.
REQ-009 SHALL have ports alu_result (input, W) and alu_negative, alu_overflow, alu_zero, alu_cout (input, 1 each), the ALU result and flags.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-012 SHALL have port rsp_id  output  1  requester owning the response.
REQ-013 SHALL have port rsp_result  output  W  registered ALU result.
REQ-014 SHALL have port rsp_flags  output  4  registered flags {negative, overflow, zero, cout}.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-017 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready for exactly one cycle, latch its opcode/a/b and ID into issue registers, and go to EXEC.
REQ-018 IDLE with no valid request SHALL stay IDLE with both readies low.
REQ-019 Readies SHALL be asserted only in IDLE, never to both requesters in the same cycle.
REQ-020 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; the last-grant pointer updates on each grant.
REQ-021 alu_opcode/alu_a/alu_b SHALL be driven from the issue registers in every state; they hold their last values outside EXEC.
REQ-022 EXEC (one cycle): SHALL capture alu_result into rsp_result and the four ALU flags into rsp_flags, then go to RESP.
REQ-023 RESP: SHALL assert rsp_valid with stable rsp_id/rsp_result/rsp_flags until the cycle rsp_ready is high, then go to IDLE.
REQ-024 Latency: grant in cycle T -> rsp_valid first high in cycle T+2; with rsp_ready held high, the next grant is at the earliest in T+3.
REQ-025 Requests arriving while busy SHALL wait; a reqN_valid deasserted before its grant SHALL be dropped without side effects.

Reset
REQ-026 rst_n low SHALL immediately force IDLE; rsp_valid, req0_ready, req1_ready, busy, rsp_id, rsp_result, rsp_flags, alu_opcode, alu_a, alu_b SHALL be 0; last-grant pointer SHALL be 1, so requester 0 wins the first tie.
REQ-027 Reset asserted during EXEC or RESP SHALL discard the in-flight operation; no response is produced for it after release.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIORITY_EN: when defined, requester 0 SHALL always win when both are valid (the last-grant pointer is unused); when undefined, round-robin per REQ-020 applies.

Verification
REQ-029 Single request: req0 ADD a=3 b=4, rsp_ready=1 -> req0_ready in cycle T, rsp_valid in T+2 with rsp_id=0, rsp_result=7, rsp_flags=0000.
REQ-030 Tie: req0 and req1 valid continuously -> grants 0,1,0,1 (round-robin build) or 0,0,0 (fixed-priority build).
REQ-031 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and payload stable, no readies asserted, busy=1; rsp_ready=1 -> IDLE next cycle.
REQ-032 Flags: req1 SUB a=2 b=2 -> rsp_id=1, rsp_result=0, zero flag=1, cout equal to the ALU's alu_cout.
REQ-033 Reset mid-operation: rst_n low during EXEC -> all outputs 0 at once; after release no rsp_valid occurs until a new request is granted.
REQ-034 Withdrawal: req1_valid raised then dropped while busy -> no grant to requester 1 and no response with rsp_id=1.
